// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, the NOP opcode
// and the opcode values that the control unit's decode table also uses.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    localparam int unsigned OPCODE_W = 8;

    // A timeout loads NOP into IR, and the control unit decodes NOP as a restart.
    localparam logic [OPCODE_W-1:0] OP_NOP = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_ADD = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_SUB = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_AND = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_OR  = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_XOR = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_NOT = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_SHL = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_SHR = 8'h08;
    localparam logic [OPCODE_W-1:0] OP_LD  = 8'h10;
    localparam logic [OPCODE_W-1:0] OP_ST  = 8'h11;
    localparam logic [OPCODE_W-1:0] OP_JMP = 8'h18;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 8'h19;
    localparam logic [OPCODE_W-1:0] OP_CMP = 8'h1F;

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: a register with synchronous reset and an increment enable.
// The increment wraps modulo 2^ADDR_W.
module pc_counter #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. It owns the PC and fetches opcodes over a req/ack
// interface to program memory. A fetch that gets no ack in time is aborted.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ir_load,
    input  logic               pc_load,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] IR,
    output logic [ADDR_W-1:0]  pc,
    output logic               ir_valid,
    output logic               busy,
    output logic               fault
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t       state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic [7:0]         cnt_q, cnt_d;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clock (clock),
        .reset (reset),
        .inc   (pc_load),
        .pc    (pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // The address is captured here, so a pc_load on the same edge
                // still fetches from the pre-increment PC.
                if (ir_load) begin
                    addr_d  = pc;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ir_d    = INSTR_W'(OP_NOP);
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign IR       = ir_q;
    assign ir_valid = valid_q;
    assign fault    = fault_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. The memory side is driven by hand and
// each test compares DUT outputs against values worked out for its stimulus.
module tb_instr_fetch_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ir_load = 1'b0;
    logic       pc_load = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic [7:0] IR;
    logic [7:0] pc;
    logic       ir_valid;
    logic       busy;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (8),
        .RESET_PC (8'h00),
        .TIMEOUT  (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ir_load   (ir_load),
        .pc_load   (pc_load),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .IR        (IR),
        .pc        (pc),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    // Inputs change 1ns after a rising edge and outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", pc); end
        n_checks++; if (IR !== 8'h00) begin n_fail++; $display("FAIL reset_ir: got %h expected 00", IR); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b expected 0", ir_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
    endtask

    task automatic test_basic_fetch();
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_c1: got %b expected 1", mem_req); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL basic_addr_c1: got %h expected 00", mem_addr); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_c2: got %b expected 1", mem_req); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL basic_addr_c2: got %h expected 00", mem_addr); end
        mem_ack = 1'b1;
        mem_rdata = 8'h01;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        n_checks++; if (IR !== 8'h01) begin n_fail++; $display("FAIL basic_ir: got %h expected 01", IR); end
        n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ir_valid: got %b expected 1", ir_valid); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_done: got %b expected 0", mem_req); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
    endtask

    task automatic test_slow_overlap();
        for (int i = 0; i < 5; i++) begin
            pc_load = 1'b1;
            tick();
        end
        pc_load = 1'b0;
        n_checks++; if (pc !== 8'h05) begin n_fail++; $display("FAIL slow_pc_pre: got %h expected 05", pc); end
        ir_load = 1'b1;
        pc_load = 1'b1;
        tick();
        ir_load = 1'b0;
        pc_load = 1'b0;
        n_checks++; if (pc !== 8'h06) begin n_fail++; $display("FAIL slow_pc_inc: got %h expected 06", pc); end
        n_checks++; if (mem_addr !== 8'h05) begin n_fail++; $display("FAIL slow_addr_req: got %h expected 05", mem_addr); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL slow_valid_drop: got %b expected 0", ir_valid); end
        tick();
        // Four WAIT cycles without ack; a second ir_load is pulsed in the first.
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL slow_req_wait%0d: got %b expected 1", i, mem_req); end
            n_checks++; if (mem_addr !== 8'h05) begin n_fail++; $display("FAIL slow_addr_wait%0d: got %h expected 05", i, mem_addr); end
            ir_load = (i == 0);
            tick();
            ir_load = 1'b0;
        end
        mem_ack = 1'b1;
        mem_rdata = 8'h75;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        n_checks++; if (IR !== 8'h75) begin n_fail++; $display("FAIL slow_ir: got %h expected 75", IR); end
        n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL slow_ir_valid: got %b expected 1", ir_valid); end
        n_checks++; if (pc !== 8'h06) begin n_fail++; $display("FAIL slow_pc_post: got %h expected 06", pc); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL slow_no_queue: got busy %b expected 0", busy); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL slow_no_queue_req: got %b expected 0", mem_req); end
    endtask

    task automatic test_timeout();
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick();
        // WAIT is entered with counter 0; abort happens on the 15th WAIT edge.
        for (int i = 0; i < 14; i++) begin
            tick();
            n_checks++; if (mem_req !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL timeout_early%0d: got req %b fault %b expected req 1 fault 0", i, mem_req, fault); end
        end
        tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req: got %b expected 0", mem_req); end
        n_checks++; if (IR !== 8'h00) begin n_fail++; $display("FAIL timeout_ir: got %h expected 00", IR); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_ir_valid: got %b expected 0", ir_valid); end
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b expected 1", fault); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick();
        mem_ack = 1'b1;
        mem_rdata = 8'h02;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        n_checks++; if (IR !== 8'h02) begin n_fail++; $display("FAIL timeout_refetch_ir: got %h expected 02", IR); end
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", fault); end
    endtask

    task automatic test_pc_wrap();
        for (int i = 0; i < 249; i++) begin
            pc_load = 1'b1;
            tick();
        end
        pc_load = 1'b0;
        n_checks++; if (pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_pc_ff: got %h expected ff", pc); end
        pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc_00: got %h expected 00", pc); end
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00", mem_addr); end
        // Ack while still in REQ completes the fetch on that edge.
        mem_ack = 1'b1;
        mem_rdata = 8'h1F;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        n_checks++; if (IR !== 8'h1F) begin n_fail++; $display("FAIL req_ack_ir: got %h expected 1f", IR); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_ack_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_fetch();
        pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait: got req %b expected 1", mem_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req_drop: got %b expected 0", mem_req); end
        mem_ack = 1'b1;
        mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b expected 0", mem_req); end
        n_checks++; if (IR !== 8'h00) begin n_fail++; $display("FAIL midrst_ir: got %h expected 00", IR); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ir_valid: got %b expected 0", ir_valid); end
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL midrst_pc: got %h expected 00", pc); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL midrst_fault: got %b expected 0", fault); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_fetch();
        test_slow_overlap();
        test_timeout();
        test_pc_wrap();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Responder side of the control unit's fetch interface.
- Consumes the `ir_load` and `pc_load` strobes.
- Owns the program counter.
- Runs a req/ack handshake to program memory.
- Presents the fetched 8-bit opcode on `IR` for decode.
- Sits between the control unit and instruction memory; replaces the ad-hoc IR/PC registers in the datapath.

Parameters:
- ADDR_W, 8, width of PC and memory address.
- INSTR_W, 8, opcode width; must match the control unit's IR input.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, max cycles to wait for `mem_ack` before aborting (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ir_load  in  1  fetch strobe from the control unit; one-cycle pulse.
- pc_load  in  1  PC advance strobe from the control unit; one-cycle pulse.
- mem_req  out  1  memory read request; held until ack.
- mem_addr  out  ADDR_W  read address; stable while `mem_req`=1.
- mem_rdata  in  INSTR_W  read data; valid in the `mem_ack` cycle.
- mem_ack  in  1  memory completion; single-cycle pulse.
- IR  out  INSTR_W  current instruction register.
- pc  out  ADDR_W  current program counter.
- ir_valid  out  1  IR holds data from a completed fetch.
- busy  out  1  fetch in progress (state != IDLE).
- fault  out  1  sticky; set on fetch timeout.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - state=IDLE, pc=RESET_PC, IR=0, ir_valid=0, mem_req=0, mem_addr=0, fault=0, timeout counter=0.
  - reset overrides all other inputs in the same cycle.
  - A reset mid-fetch drops `mem_req` the next cycle; a late `mem_ack` after reset is ignored (state=IDLE).
- States: IDLE, REQ, WAIT.
- IDLE:
  - on `ir_load`=1: latch mem_addr<=pc, mem_req<=1, ir_valid<=0, go REQ.
  - otherwise hold.
- REQ:
  - one cycle with `mem_req`=1; counter<=0; go WAIT.
  - if `mem_ack`=1 in REQ, treat as in WAIT (complete immediately).
- WAIT:
  - `mem_req` stays 1 and `mem_addr` is held.
  - on `mem_ack`=1: IR<=mem_rdata, ir_valid<=1, mem_req<=0, go IDLE.
  - else counter increments.
  - when counter reaches TIMEOUT-1 without ack: IR<=0 (NOP; decodes to restart), ir_valid<=0, fault<=1, mem_req<=0, go IDLE.
- Latency:
  - ack in the first WAIT cycle puts IR valid 3 clocks after the `ir_load` edge.
  - in general, IR is valid 3 + (wait cycles) clocks after the `ir_load` edge.
- `ir_load` while busy: ignored (no queueing); `busy` informs the control unit.
- `pc_load`:
  - pc<=pc+1 modulo 2^ADDR_W (wraps from all-ones to 0) in any state.
  - `mem_addr` is registered at request start, so an in-flight fetch is unaffected.
- Simultaneous `ir_load` and `pc_load` in IDLE: fetch uses the pre-increment pc; pc increments the same edge.
- `fault` clears only on reset.
- `IR` holds its value between fetches; it changes only on ack, timeout, or reset.
- Outputs are registered; no combinational path from `mem_ack`/`mem_rdata` to outputs.

Decomposition:
- Shared package:
  - state encoding constants (IDLE, REQ, WAIT).
  - NOP opcode constant 8'h00.
  - opcode constants shared with the control unit's decode table (ADD=8'h01, SUB=8'h02, ... CMP=8'h1F).
- One natural sub-module: `pc_counter`.
  - ADDR_W-bit register with synchronous reset to RESET_PC and increment-enable.
  - Wrap-around modulo 2^ADDR_W.
- FSM, IR register and timeout counter stay in the top module.

Test Plan:
- Reset state: assert reset 2 cycles, then release:
  - pc=0x00, IR=0x00, ir_valid=0, busy=0, mem_req=0, fault=0.
- Basic fetch: pc=0x00, pulse `ir_load`, memory acks in the first WAIT cycle with 0x01:
  - mem_req high 2 cycles with mem_addr=0x00.
  - IR=0x01 and ir_valid=1 three clocks after the pulse.
  - busy back to 0.
- Slow memory plus overlapping strobes:
  - pc=0x05, `ir_load` and `pc_load` in the same cycle; ack after 4 wait cycles with 0x75.
  - mem_addr=0x05 throughout, pc=0x06.
  - a second `ir_load` during WAIT is ignored.
  - IR=0x75.
- Timeout: TIMEOUT=15, `ir_load`, no ack:
  - after 15 WAIT cycles: mem_req=0, IR=0x00, ir_valid=0, fault=1.
  - a subsequent successful fetch leaves fault=1.
- PC wrap: pc=0xFF, pulse `pc_load`:
  - pc=0x00.
  - next fetch presents mem_addr=0x00.
- Reset mid-fetch: reset asserted in WAIT, `mem_ack` with 0x3C one cycle later:
  - state IDLE, mem_req=0, IR=0x00 (ack ignored), pc=RESET_PC.
